instr_encoder_loader: RTL
=========================

Name: instr_encoder_loader

Overview:
- Inverse of the instruction decoder: accepts decoded operation fields over a valid/ready stream and encodes each into a 32-bit instruction word.
- Buffers encoded words in a small FIFO and writes them sequentially into instruction memory, starting at a programmable base address.
- Sits between the test/program-load path and the instruction memory write port; used to load programs before the processor runs.

Parameters:
- ADDR_W, 8, instruction memory word-address width.
- DEPTH, 4, FIFO depth in words (power of two, >= 2).
- OP_ALUR, 4'b1100, opcode for ALU register form.
- OP_ALUI, 4'b0100, opcode for ALU immediate form.
- OP_CMPR, 4'b1101, opcode for compare register form.
- OP_CMPI, 4'b0101, opcode for compare immediate form.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load session (honoured only in IDLE).
- base_addr  input  ADDR_W  first memory address; sampled on an accepted start.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  bundle accepted when in_valid && in_ready.
- in_last  input  1  marks the final bundle of the session.
- in_kind  input  2  0=ALUR, 1=ALUI, 2=CMPR, 3=CMPI.
- in_fn  input  4  function code, placed in bits [31:28].
- in_rd, in_rs1, in_rs2  input  4 each  register numbers.
- in_imm  input  16  immediate, used by the immediate forms only.
- mem_wr_en  output  1  write request.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  32  encoded instruction word.
- mem_ready  input  1  memory accepts the write this cycle.
- busy  output  1  high in LOAD or DRAIN.
- done  output  1  one-cycle pulse on session completion.
- err_overflow  output  1  sticky address-overflow flag.
- word_count  output  ADDR_W+1  words written in the current session.

Behaviour:
- Encoding, combinational at push:
  - [31:28]=in_fn; [27:24]=opcode selected by in_kind; [7:4]=in_rs1; [3:0]=in_rd.
  - Register forms: [23:12]=0, [11:8]=in_rs2.
  - Immediate forms: [23:8]=in_imm; in_rs2 is ignored.
- States: IDLE, LOAD, DRAIN, ERR.
  - IDLE: start loads mem_addr<=base_addr, word_count<=0, then goes to LOAD.
  - LOAD: accepting a bundle with in_last=1 goes to DRAIN.
  - DRAIN: FIFO empty goes to IDLE with done=1 for exactly one cycle.
  - ERR: stays until reset; start is ignored.
- in_ready = (state==LOAD) && !fifo_full. No push when full, even if a pop occurs in the same cycle. in_ready=0 in IDLE, DRAIN and ERR.
- Push and pop in the same cycle with the FIFO neither full nor empty: occupancy is unchanged.
- Write side:
  - mem_wr_en = (state is LOAD or DRAIN) && !fifo_empty.
  - mem_wdata = FIFO head. mem_addr is a register.
  - A write completes when mem_wr_en && mem_ready. Completion pops the FIFO, increments mem_addr and increments word_count.
  - mem_addr and mem_wdata stay stable while mem_wr_en=1 and mem_ready=0.
- Latency: a bundle accepted at cycle N into an empty FIFO gives mem_wr_en=1 at cycle N+1.
- Overflow: a write completes at mem_addr = 2^ADDR_W-1 while the FIFO still holds entries, or while in LOAD without in_last seen:
  - err_overflow<=1 and the block enters ERR; the completed write stands.
  - In ERR, mem_wr_en=0 and the FIFO contents are discarded.
  - A final write at the top address with no words remaining is legal and mem_addr wraps to 0.
- start while not in IDLE: ignored.
- Reset values, from any state including mid-session:
  - state=IDLE, FIFO empty, mem_addr=0, word_count=0.
  - in_ready=0, mem_wr_en=0, busy=0, done=0, err_overflow=0.
  - mem_wdata is don't-care while mem_wr_en=0.

Test Plan:
- ALUR encoding: start with base_addr=0x10; bundle ALUR, fn=0, rd=3, rs1=1, rs2=2, last=1; mem_ready=1 -> one write, addr 0x10, data 0x0C000213; done pulses; word_count=1.
- ALUI encoding: bundle ALUI, fn=0, rd=6, rs1=5, rs2=0xF, imm=0x1234 -> data 0x04123456 (rs2 ignored).
- Backpressure: mem_ready=0 while 5 bundles are offered -> in_ready drops after 4 accepted; addr and data held stable. Release mem_ready -> 5 writes at consecutive addresses, in order; done only after the 5th.
- Overflow: base_addr=0xFE, 3 bundles -> writes at 0xFE and 0xFF, then err_overflow=1, ERR state, no third write, done never pulses. Also: 2 bundles from 0xFE -> done, no error.
- Reset mid-DRAIN with 2 queued words -> next cycle mem_wr_en=0, in_ready=0, word_count=0. A new start works normally.
- Protocol: start pulsed during LOAD is ignored (mem_addr unchanged); in_valid asserted in IDLE is never accepted.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// ----------------------------------------------------------------------------
// instr_encoder_loader
//
// Encodes decoded operation fields into 32-bit instruction words and writes
// them one after another into instruction memory, starting at a base address.
// Used on the program-load path before the processor starts running.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   start         one-cycle pulse; begins a load session (IDLE only)
//   base_addr     first write address, captured on an accepted start
//   in_valid      field bundle valid
//   in_ready      bundle accepted when in_valid && in_ready
//   in_last       final bundle of the session
//   in_kind       0=ALUR, 1=ALUI, 2=CMPR, 3=CMPI
//   in_fn         function code -> word[31:28]
//   in_rd/rs1/rs2 register numbers
//   in_imm        immediate, immediate forms only
//   mem_wr_en     memory write request
//   mem_addr      memory write address
//   mem_wdata     encoded instruction word (FIFO head)
//   mem_ready     memory accepts the write this cycle
//   busy          session in progress (LOAD or DRAIN)
//   done          one-cycle pulse when a session completes cleanly
//   err_overflow  sticky: words remained when the top address was written
//   word_count    words written in the current session
// ----------------------------------------------------------------------------
module instr_encoder_loader #(
   parameter int         ADDR_W  = 8,
   parameter int         DEPTH   = 4,
   parameter logic [3:0] OP_ALUR = 4'b1100,
   parameter logic [3:0] OP_ALUI = 4'b0100,
   parameter logic [3:0] OP_CMPR = 4'b1101,
   parameter logic [3:0] OP_CMPI = 4'b0101
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [1:0]        in_kind,
   input  logic [3:0]        in_fn,
   input  logic [3:0]        in_rd,
   input  logic [3:0]        in_rs1,
   input  logic [3:0]        in_rs2,
   input  logic [15:0]       in_imm,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ready,
   output logic              busy,
   output logic              done,
   output logic              err_overflow,
   output logic [ADDR_W:0]   word_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int WC_W  = ADDR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DRAIN,
      ST_ERR
   } state_t;

   state_t             r_state;
   state_t             w_state_next;

   logic [31:0]        r_fifo [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;
   logic [ADDR_W-1:0]  r_mem_addr;
   logic [WC_W-1:0]    r_word_count;
   logic               r_err_overflow;

   logic               w_full;
   logic               w_empty;
   logic               w_push;
   logic               w_pop;
   logic               w_top_addr;
   logic               w_overflow;
   logic [3:0]         w_opcode;
   logic [15:0]        w_mid;
   logic [31:0]        w_enc_word;

   // ---------------------------------------------------------------- encoder
   always_comb begin
      case (in_kind)
         2'd0:    w_opcode = OP_ALUR;
         2'd1:    w_opcode = OP_ALUI;
         2'd2:    w_opcode = OP_CMPR;
         default: w_opcode = OP_CMPI;
      endcase
      // Odd kinds are the immediate forms; register forms zero bits [23:12].
      w_mid      = in_kind[0] ? in_imm : {12'h000, in_rs2};
      w_enc_word = {in_fn, w_opcode, w_mid, in_rs1, in_rd};
   end

   // -------------------------------------------------------- handshake terms
   assign w_full     = (r_count == CNT_W'(DEPTH));
   assign w_empty    = (r_count == '0);
   assign in_ready   = (r_state == ST_LOAD) && !w_full;
   assign busy       = (r_state == ST_LOAD) || (r_state == ST_DRAIN);
   assign mem_wr_en  = busy && !w_empty;
   assign w_push     = in_valid && in_ready;
   assign w_pop      = mem_wr_en && mem_ready;
   assign w_top_addr = (r_mem_addr == {ADDR_W{1'b1}});

   // Writing the top address is only legal for the very last word. More words
   // are owed if the FIFO keeps entries after this pop, a word arrives in the
   // same cycle, or we are still in LOAD (in_last not yet accepted).
   assign w_overflow = w_pop && w_top_addr &&
                       ((r_count > CNT_W'(1)) || w_push || (r_state == ST_LOAD));

   // ------------------------------------------------------------------- FSM
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block evaluation order.
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   // NOTE: every output of this block gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      w_state_next = r_state;
      done         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) w_state_next = ST_LOAD;
         end
         ST_LOAD: begin
            if (w_overflow)            w_state_next = ST_ERR;
            else if (w_push && in_last) w_state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (w_overflow) begin
               w_state_next = ST_ERR;
            end else if (w_empty) begin
               w_state_next = ST_IDLE;
               done         = 1'b1;
            end
         end
         ST_ERR:  w_state_next = ST_ERR;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // ------------------------------------------------- FIFO control, counters
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
         r_mem_addr     <= '0;
         r_word_count   <= '0;
         r_err_overflow <= 1'b0;
      end else begin
         if ((r_state == ST_IDLE) && start) begin
            r_mem_addr   <= base_addr;
            r_word_count <= '0;
         end

         // Top address wraps to 0 naturally on the last legal write.
         if (w_pop) begin
            r_mem_addr   <= r_mem_addr + ADDR_W'(1);
            r_word_count <= r_word_count + WC_W'(1);
         end

         if (w_overflow) begin
            // Entering ERR: the completed write stands, queued words are dropped.
            r_err_overflow <= 1'b1;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + CNT_W'(1);
               2'b01:   r_count <= r_count - CNT_W'(1);
               default: r_count <= r_count;
            endcase
         end
      end
   end

   // NOTE: FIFO storage is deliberately not reset; r_count alone decides
   // which entries are valid, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (w_push) r_fifo[r_wr_ptr] <= w_enc_word;
   end

   assign mem_wdata    = r_fifo[r_rd_ptr];
   assign mem_addr     = r_mem_addr;
   assign word_count   = r_word_count;
   assign err_overflow = r_err_overflow;

endmodule
